// File: rtl/rom_loader.sv
// ioctl download router for the pacman core: ROM bytes to dn_* port, variant and DIP latches,
// core reset sequencing with completeness/overrun/checksum reporting.
module rom_loader #(
    parameter int unsigned ROM_SIZE    = 65536,
    parameter int unsigned HOLD_CYCLES = 1024,
    parameter bit          PRELOADED   = 1'b0
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        user_reset,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic [7:0]  mod,
    output logic [63:0] dip_sw,
    output logic        core_reset,
    output logic        rom_valid,
    output logic        overrun,
    output logic [7:0]  rom_sum
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_FAIL} state_t;

    localparam int unsigned    HW          = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]  HOLD_RELOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [16:0]    CNT_FULL    = 17'(ROM_SIZE);
    localparam logic [24:0]    ADDR_LIMIT  = 25'(ROM_SIZE);

    state_t         r_state;
    logic [HW-1:0]  r_hold_cnt;
    logic [16:0]    r_count;
    logic           r_dl_q;
    logic [15:0]    r_dn_addr;
    logic [7:0]     r_dn_data;
    logic           r_dn_wr;
    logic [7:0]     r_mod;
    logic [63:0]    r_dip_sw;
    logic           r_core_reset;
    logic           r_rom_valid;
    logic           r_overrun;
    logic [7:0]     r_rom_sum;

    logic           w_dl_rise;
    logic           w_dl_fall;
    logic           w_rom_wr;
    logic           w_in_range;
    logic           w_accept;
    logic [16:0]    w_count_next;
    logic           w_overrun_next;

    assign w_dl_rise      = ioctl_download && !r_dl_q && (ioctl_index == 8'd0);
    assign w_dl_fall      = !ioctl_download && r_dl_q;
    assign w_rom_wr       = (r_state == S_LOAD) && ioctl_wr && (ioctl_index == 8'd0);
    assign w_in_range     = ioctl_addr < ADDR_LIMIT;
    assign w_accept       = w_rom_wr && w_in_range;
    // Next-cycle count/overrun let a strobe coincident with the falling edge count toward rom_valid.
    assign w_count_next   = (w_accept && (r_count != CNT_FULL)) ? r_count + 17'd1 : r_count;
    assign w_overrun_next = r_overrun || (w_rom_wr && !w_in_range);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= PRELOADED ? S_HOLD : S_IDLE;
            r_hold_cnt   <= HOLD_RELOAD;
            r_count      <= '0;
            r_dl_q       <= 1'b0;
            r_dn_addr    <= '0;
            r_dn_data    <= '0;
            r_dn_wr      <= 1'b0;
            r_mod        <= '0;
            r_dip_sw     <= '1;
            r_core_reset <= 1'b1;
            r_rom_valid  <= PRELOADED;
            r_overrun    <= 1'b0;
            r_rom_sum    <= '0;
        end else begin
            r_dl_q  <= ioctl_download;
            r_dn_wr <= 1'b0;

            if (ioctl_wr && ioctl_download && (ioctl_index == 8'd1) && (ioctl_addr == 25'd0))
                r_mod <= ioctl_dout;
            if (ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr[24:3] == 22'd0))
                r_dip_sw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;

            if (w_dl_rise) begin
                r_state      <= S_LOAD;
                r_core_reset <= 1'b1;
                r_rom_valid  <= 1'b0;
                r_overrun    <= 1'b0;
                r_rom_sum    <= '0;
                r_count      <= '0;
            end else begin
                case (r_state)
                    S_LOAD: begin
                        if (w_accept) begin
                            r_dn_wr   <= 1'b1;
                            r_dn_addr <= ioctl_addr[15:0];
                            r_dn_data <= ioctl_dout;
                            r_rom_sum <= r_rom_sum + ioctl_dout;
                        end
                        r_count   <= w_count_next;
                        r_overrun <= w_overrun_next;
                        if (w_dl_fall) begin
                            r_state     <= S_HOLD;
                            r_hold_cnt  <= HOLD_RELOAD;
                            r_rom_valid <= (w_count_next == CNT_FULL) && !w_overrun_next;
                        end
                    end
                    S_HOLD: begin
                        if (user_reset) begin
                            r_hold_cnt <= HOLD_RELOAD;
                        end else if (r_hold_cnt == '0) begin
                            r_state      <= r_rom_valid ? S_RUN : S_FAIL;
                            r_core_reset <= !r_rom_valid;
                        end else begin
                            r_hold_cnt <= r_hold_cnt - HW'(1);
                        end
                    end
                    S_RUN: begin
                        if (user_reset) begin
                            r_state      <= S_HOLD;
                            r_hold_cnt   <= HOLD_RELOAD;
                            r_core_reset <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign dn_addr    = r_dn_addr;
    assign dn_data    = r_dn_data;
    assign dn_wr      = r_dn_wr;
    assign mod        = r_mod;
    assign dip_sw     = r_dip_sw;
    assign core_reset = r_core_reset;
    assign rom_valid  = r_rom_valid;
    assign overrun    = r_overrun;
    assign rom_sum    = r_rom_sum;

endmodule

// File: tb/tb_rom_loader.sv
// Directed self-checking bench for rom_loader (ROM_SIZE=4, HOLD_CYCLES=3), with a PRELOADED twin.
module tb_rom_loader;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        user_reset;

    logic [15:0] dn_addr,    p_dn_addr;
    logic [7:0]  dn_data,    p_dn_data;
    logic        dn_wr,      p_dn_wr;
    logic [7:0]  mod,        p_mod;
    logic [63:0] dip_sw,     p_dip_sw;
    logic        core_reset, p_core_reset;
    logic        rom_valid,  p_rom_valid;
    logic        overrun,    p_overrun;
    logic [7:0]  rom_sum,    p_rom_sum;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [7:0] rom_bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    always #5 clk_sys = ~clk_sys;

    rom_loader #(.ROM_SIZE(4), .HOLD_CYCLES(3), .PRELOADED(1'b0)) u_dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .user_reset(user_reset),
        .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr), .mod(mod), .dip_sw(dip_sw),
        .core_reset(core_reset), .rom_valid(rom_valid), .overrun(overrun), .rom_sum(rom_sum)
    );

    rom_loader #(.ROM_SIZE(4), .HOLD_CYCLES(3), .PRELOADED(1'b1)) u_dut_pre (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .user_reset(user_reset),
        .dn_addr(p_dn_addr), .dn_data(p_dn_data), .dn_wr(p_dn_wr), .mod(p_mod), .dip_sw(p_dip_sw),
        .core_reset(p_core_reset), .rom_valid(p_rom_valid), .overrun(p_overrun), .rom_sum(p_rom_sum)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic start_dl();
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    // Writes the first n ROM bytes, checking each dn_wr pulse and its one-cycle width.
    task automatic load_bytes(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            wr_byte(25'(i), rom_bytes[i]);
            check("dn_wr_pulse", dn_wr, 1'b1);
            check("dn_addr", dn_addr, 16'(i));
            check("dn_data", dn_data, rom_bytes[i]);
            tick();
            check("dn_wr_width", dn_wr, 1'b0);
        end
    endtask

    task automatic end_dl_check(input logic exp_valid);
        ioctl_download = 1'b0;
        tick();
        check("hold_valid", rom_valid, exp_valid);
        check("hold_cr0", core_reset, 1'b1);
        tick();
        check("hold_cr1", core_reset, 1'b1);
        tick();
        check("hold_cr2", core_reset, 1'b1);
        tick();
        check("hold_exit_cr", core_reset, !exp_valid);
    endtask

    initial begin
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        user_reset     = 1'b0;
        #12;
        check("rst_dn_wr", dn_wr, 1'b0);
        check("rst_dn_addr", dn_addr, 16'h0);
        check("rst_dn_data", dn_data, 8'h0);
        check("rst_mod", mod, 8'h0);
        check("rst_dip", dip_sw, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rst_core_reset", core_reset, 1'b1);
        check("rst_rom_valid", rom_valid, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_rom_sum", rom_sum, 8'h0);
        check("pre_rst_valid", p_rom_valid, 1'b1);
        check("pre_rst_cr", p_core_reset, 1'b1);
        check("pre_rst_misc", {p_dn_addr, p_dn_data, p_dn_wr, p_mod, p_overrun, p_rom_sum}, '0);
        check("pre_rst_dip", p_dip_sw, 64'hFFFF_FFFF_FFFF_FFFF);

        @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        for (int unsigned k = 0; k < 3; k++) begin
            tick();
            check("pre_valid", p_rom_valid, 1'b1);
            check("pre_cr", p_core_reset, (k < 2) ? 1'b1 : 1'b0);
        end
        check("idle_cr", core_reset, 1'b1);

        // Full download
        start_dl();
        load_bytes(4);
        check("sum_full", rom_sum, 8'hAA);
        check("ovr_full", overrun, 1'b0);
        end_dl_check(1'b1);

        // User reset for 5 cycles in RUN
        user_reset = 1'b1;
        for (int unsigned k = 0; k < 5; k++) begin
            tick();
            check("ureset_hi_cr", core_reset, 1'b1);
        end
        user_reset = 1'b0;
        tick();
        check("ureset_lo_cr0", core_reset, 1'b1);
        tick();
        check("ureset_lo_cr1", core_reset, 1'b1);
        tick();
        check("ureset_lo_cr2", core_reset, 1'b0);
        check("ureset_valid", rom_valid, 1'b1);

        // Overrun: fifth byte at addr 4
        start_dl();
        check("start_valid_clr", rom_valid, 1'b0);
        load_bytes(4);
        wr_byte(25'd4, 8'h55);
        check("ovr_no_dn_wr", dn_wr, 1'b0);
        check("ovr_set", overrun, 1'b1);
        check("ovr_sum", rom_sum, 8'hAA);
        end_dl_check(1'b0);
        user_reset = 1'b1;
        tick();
        user_reset = 1'b0;
        for (int unsigned k = 0; k < 5; k++) tick();
        check("fail_stuck_cr", core_reset, 1'b1);
        start_dl();
        check("ovr_cleared", overrun, 1'b0);
        check("sum_cleared", rom_sum, 8'h00);
        load_bytes(4);
        end_dl_check(1'b1);

        // Short download
        start_dl();
        load_bytes(3);
        check("short_sum", rom_sum, 8'h66);
        end_dl_check(1'b0);
        tick();
        check("short_fail_cr", core_reset, 1'b1);

        // Last strobe coincident with download falling edge
        start_dl();
        load_bytes(3);
        ioctl_addr     = 25'd3;
        ioctl_dout     = 8'h44;
        ioctl_wr       = 1'b1;
        ioctl_download = 1'b0;
        tick();
        ioctl_wr = 1'b0;
        check("edge_dn_wr", dn_wr, 1'b1);
        check("edge_valid", rom_valid, 1'b1);
        check("edge_sum", rom_sum, 8'hAA);
        tick();
        tick();
        tick();
        check("edge_run_cr", core_reset, 1'b0);

        // Index 1: game variant
        ioctl_index    = 8'd1;
        ioctl_download = 1'b1;
        tick();
        wr_byte(25'd0, 8'h0B);
        check("mod_set", mod, 8'h0B);
        wr_byte(25'd1, 8'h05);
        check("mod_hold", mod, 8'h0B);
        check("mod_run_cr", core_reset, 1'b0);
        ioctl_download = 1'b0;
        tick();

        // Index 254: DIP switches
        ioctl_index    = 8'd254;
        ioctl_download = 1'b1;
        tick();
        wr_byte(25'd2, 8'h7E);
        check("dip_byte2", dip_sw, 64'hFFFF_FFFF_FF7E_FFFF);
        wr_byte(25'd8, 8'h00);
        check("dip_addr8", dip_sw, 64'hFFFF_FFFF_FF7E_FFFF);
        check("dip_run_cr", core_reset, 1'b0);
        ioctl_download = 1'b0;
        tick();

        // Reset asserted mid-LOAD
        start_dl();
        wr_byte(25'd0, 8'h11);
        check("mid_dn_wr_pre", dn_wr, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_dn_wr", dn_wr, 1'b0);
        check("mid_cr", core_reset, 1'b1);
        check("mid_valid", rom_valid, 1'b0);
        check("mid_sum", rom_sum, 8'h00);
        ioctl_download = 1'b0;
        tick();
        reset_n = 1'b1;
        ioctl_index = 8'd0;
        wr_byte(25'd1, 8'h55);
        check("idle_strobe_dn_wr", dn_wr, 1'b0);
        check("idle_strobe_sum", rom_sum, 8'h00);
        for (int unsigned k = 0; k < 4; k++) tick();
        check("idle_after_cr", core_reset, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
